dac_arbiter: RTL
================

DAC_ARBITER -- requirements
Module: dac_arbiter

Interface
REQ-001 SHALL have parameter DAC_WID, default 24, width of DAC SPI word (4-bit register code + 20-bit data).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1000, maximum idle-locked cycles before forced release.
REQ-003 SHALL have parameter TIMER_WID, default 16, width of lock watchdog counter.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_L  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports loop_arm / cpu_arm  in  1  requester transaction request, held until finished.
REQ-007 SHALL have ports loop_ss / cpu_ss  in  1  requester chip-select.
REQ-008 SHALL have ports loop_lock / cpu_lock  in  1  keep grant across consecutive transactions.
REQ-009 SHALL have ports loop_to_dac / cpu_to_dac  in  DAC_WID  requester SPI word.
REQ-010 SHALL have ports loop_from_dac / cpu_from_dac  out  DAC_WID  readback word.
REQ-011 SHALL have ports loop_finished / cpu_finished  out  1  transaction done, gated to granted requester.
REQ-012 SHALL have ports loop_granted / cpu_granted  out  1  requester owns the DAC master.
REQ-013 SHALL have ports mst_arm, mst_ss  out  1  and mst_to_dac  out  DAC_WID  to the SPI master.
REQ-014 SHALL have ports mst_from_dac  in  DAC_WID  and mst_finished  in  1  from the SPI master.
REQ-015 SHALL have port lock_timeout  out  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement states IDLE, GRANT_LOOP, GRANT_CPU, HANDOVER in a registered state machine.
REQ-017 IDLE: one requester with arm=1 -> grant it next cycle; none -> stay IDLE.
REQ-018 IDLE with both arms high SHALL grant the requester not granted last (last_grant register, round-robin).
REQ-019 Grant latency SHALL be exactly 1 cycle: arm seen high at edge n, x_granted=1 and mst_arm=x_arm from cycle n+1.
REQ-020 While granted, mst_arm/mst_ss/mst_to_dac SHALL combinationally follow the granted requester; in IDLE/HANDOVER they SHALL be 0.
REQ-021 x_finished SHALL equal mst_finished only while x is granted, else 0; x_from_dac SHALL be a register loaded from mst_from_dac on mst_finished while x granted, held otherwise.
REQ-022 Grant SHALL be kept while granted arm=1, or arm=0 with lock=1.
REQ-023 Granted arm=0 and lock=0 SHALL move to HANDOVER; HANDOVER SHALL last exactly 1 cycle then go to IDLE.
REQ-024 Watchdog SHALL count cycles with granted arm=0 and lock=1, clearing on arm=1 or state change.
REQ-025 Counter reaching LOCK_TIMEOUT SHALL force HANDOVER and pulse lock_timeout for 1 cycle.
REQ-026 Non-granted requester arm SHALL be ignored (no effect on master) until arbitration in IDLE.
REQ-027 On each grant, last_grant SHALL update to the granted requester.
REQ-028 Arm dropped before mst_finished SHALL be passed through unchanged; abort handling is the SPI master's concern.
REQ-029 Watchdog counter SHALL saturate at LOCK_TIMEOUT, never wrap.

Reset
REQ-030 rst_L=0 SHALL immediately force state IDLE, last_grant=CPU, watchdog=0, x_from_dac=0, and every output to 0.
REQ-031 Reset mid-transaction SHALL drop mst_arm and mst_ss the same cycle, without waiting for clk.
REQ-032 After rst_L release, the first simultaneous request SHALL be granted to loop.

Verification
REQ-033 Reset release, loop_arm=1 and cpu_arm=1 same cycle -> loop_granted=1 next cycle, cpu waits; after loop_arm=0, lock=0: 1 HANDOVER cycle, then cpu_granted.
REQ-034 Loop lock=1, read 0x900000, arm low 3 cycles, write 0x1ABCDE -> grant kept throughout, cpu_arm high whole time is never granted, mst_ss=0 between transactions.
REQ-035 LOCK_TIMEOUT=8, loop lock=1, arm=0 -> lock_timeout pulses after 8 idle cycles, HANDOVER, IDLE.
REQ-036 cpu granted, mst_from_dac=0x0F1234 with mst_finished -> cpu_from_dac=0x0F1234, loop_from_dac unchanged, loop_finished stays 0.
REQ-037 rst_L low while cpu granted with mst_arm=1 -> mst_arm, mst_ss, cpu_granted all 0 before next clk edge.
REQ-038 Alternating simultaneous requests over 6 grants -> order loop, cpu, loop, cpu, loop, cpu.

Source files
------------

// File: rtl/dac_arbiter.sv
// rtl/dac_arbiter.sv - two-requester (loop/cpu) arbiter in front of one DAC SPI master
`timescale 1ns/1ps
module dac_arbiter #(
  parameter int DAC_WID      = 24,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int TIMER_WID    = 16
) (
  input  logic               clk,
  input  logic               rst_L,
  input  logic               loop_arm,
  input  logic               loop_ss,
  input  logic               loop_lock,
  input  logic [DAC_WID-1:0] loop_to_dac,
  output logic [DAC_WID-1:0] loop_from_dac,
  output logic               loop_finished,
  output logic               loop_granted,
  input  logic               cpu_arm,
  input  logic               cpu_ss,
  input  logic               cpu_lock,
  input  logic [DAC_WID-1:0] cpu_to_dac,
  output logic [DAC_WID-1:0] cpu_from_dac,
  output logic               cpu_finished,
  output logic               cpu_granted,
  output logic               mst_arm,
  output logic               mst_ss,
  output logic [DAC_WID-1:0] mst_to_dac,
  input  logic [DAC_WID-1:0] mst_from_dac,
  input  logic               mst_finished,
  output logic               lock_timeout
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT_LOOP = 2'd1,
    S_GRANT_CPU  = 2'd2,
    S_HANDOVER   = 2'd3
  } state_t;

  localparam logic [TIMER_WID-1:0] C_WD_LAST = TIMER_WID'(LOCK_TIMEOUT - 1);

  state_t               r_state;
  logic                 r_last_cpu;
  logic [TIMER_WID-1:0] r_wd;
  logic                 r_lock_timeout;
  logic [DAC_WID-1:0]   r_loop_from_dac;
  logic [DAC_WID-1:0]   r_cpu_from_dac;

  logic w_loop_g;
  logic w_cpu_g;
  logic w_arm;
  logic w_lock;

  // Outputs are decoded from the state register, so the asynchronous reset
  // drops the master interface immediately.
  assign w_loop_g = (r_state == S_GRANT_LOOP);
  assign w_cpu_g  = (r_state == S_GRANT_CPU);
  assign w_arm    = (w_loop_g & loop_arm)  | (w_cpu_g & cpu_arm);
  assign w_lock   = (w_loop_g & loop_lock) | (w_cpu_g & cpu_lock);

  assign mst_arm    = w_arm;
  assign mst_ss     = (w_loop_g & loop_ss) | (w_cpu_g & cpu_ss);
  assign mst_to_dac = w_loop_g ? loop_to_dac : (w_cpu_g ? cpu_to_dac : '0);

  assign loop_granted  = w_loop_g;
  assign cpu_granted   = w_cpu_g;
  assign loop_finished = w_loop_g & mst_finished;
  assign cpu_finished  = w_cpu_g & mst_finished;
  assign loop_from_dac = r_loop_from_dac;
  assign cpu_from_dac  = r_cpu_from_dac;
  assign lock_timeout  = r_lock_timeout;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state         <= S_IDLE;
      r_last_cpu      <= 1'b1;
      r_wd            <= '0;
      r_lock_timeout  <= 1'b0;
      r_loop_from_dac <= '0;
      r_cpu_from_dac  <= '0;
    end else begin
      r_lock_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // On a tie, the requester that did not hold the DAC last wins.
          if (loop_arm && (!cpu_arm || r_last_cpu)) begin
            r_state    <= S_GRANT_LOOP;
            r_last_cpu <= 1'b0;
          end else if (cpu_arm) begin
            r_state    <= S_GRANT_CPU;
            r_last_cpu <= 1'b1;
          end
        end
        S_GRANT_LOOP, S_GRANT_CPU: begin
          if (w_arm) begin
            r_wd <= '0;
          end else if (w_lock) begin
            // Counter never passes LOCK_TIMEOUT-1: reaching the limit releases.
            if (r_wd >= C_WD_LAST) begin
              r_state        <= S_HANDOVER;
              r_wd           <= '0;
              r_lock_timeout <= 1'b1;
            end else begin
              r_wd <= r_wd + TIMER_WID'(1);
            end
          end else begin
            r_state <= S_HANDOVER;
            r_wd    <= '0;
          end
        end
        S_HANDOVER: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
      if (w_loop_g && mst_finished) r_loop_from_dac <= mst_from_dac;
      if (w_cpu_g && mst_finished)  r_cpu_from_dac  <= mst_from_dac;
    end
  end

endmodule
